// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: the memory request/response channel plus the decoder/redirect side.
// master is the fetch unit; slave is the memory/decoder environment.
interface fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, enable,
    input  mem_gnt, mem_rvalid, mem_rdata, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, enable,
    output mem_gnt, mem_rvalid, mem_rdata, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a small in-order buffer
// to the decoder, with redirect flush and drop of in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(BUF_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BUF_DEPTH - 1);
  // Canonical no-op instruction word (addi x0, x0, 0).
  localparam logic [31:0] NO_OP = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     gnt_addr_q, gnt_addr_d;
  logic            drop_q, drop_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     buf_instr_q [BUF_DEPTH];
  logic [31:0]     buf_pc_q    [BUF_DEPTH];

  logic        rsp, push, pop, empty;
  logic [31:0] redirect_addr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign redirect_addr = bus.redirect_pc & 32'hFFFF_FFFC;
  assign empty         = (count_q == '0);
  assign rsp           = (state_q == StWait) && bus.mem_rvalid;
  // Responses owed to a flushed stream, or racing a redirect, never enter the buffer.
  assign push          = rsp && !drop_q && !bus.redirect;
  assign pop           = !empty && bus.dec_ready && !bus.redirect;

  // rst gates mem_req so the request is low while reset is held, high right after release.
  assign bus.mem_req  = rst && (state_q == StReq);
  assign bus.mem_addr = pc_q;
  assign bus.enable   = pop;
  assign bus.instr    = empty ? NO_OP : buf_instr_q[rd_ptr_q];
  assign bus.instr_pc = empty ? 32'h0 : buf_pc_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    gnt_addr_d = gnt_addr_q;
    drop_d     = drop_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);

    unique case (state_q)
      StReq: begin
        if (bus.mem_gnt) begin
          state_d    = StWait;
          gnt_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
        end
      end
      StWait: begin
        if (bus.mem_rvalid) begin
          drop_d  = 1'b0;
          state_d = (count_d < DepthC) ? StReq : StHold;
        end
      end
      StHold: begin
        if (pop) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    if (bus.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = redirect_addr;
      // A grant taken now, or one still waiting for its data, must have its response dropped.
      if ((state_q == StReq && bus.mem_gnt) || (state_q == StWait && !bus.mem_rvalid)) begin
        drop_d = 1'b1;
      end
      if (state_q == StHold) state_d = StReq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      gnt_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      gnt_addr_q <= gnt_addr_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= bus.mem_rdata;
      buf_pc_q[wr_ptr_q]    <= gnt_addr_q;
    end
  end

  // The issue condition guarantees room for every granted response.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count_q == DepthC));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a latency-configurable memory model answers grants,
// stimulus queues expected {pc, instr} pairs, and a monitor checks every enable pulse.
module tb_fetch_unit;

  localparam logic [31:0] NoOp = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t exp_q[$];

  // Memory model state.
  int unsigned grants_done = 0;
  int unsigned grant_limit = 0;
  int unsigned rsp_lat     = 1;
  logic        pend        = 1'b0;
  int unsigned cnt         = 0;
  logic [31:0] paddr       = 32'h0;
  logic        rv_r        = 1'b0;
  logic [31:0] rd_r        = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc  = start + 32'(4 * i);
      e.ins = memf(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Memory ignores reset, so a response owed from before reset can still appear.
  assign bus.mem_gnt    = (grants_done < grant_limit);
  assign bus.mem_rvalid = rv_r;
  assign bus.mem_rdata  = rd_r;

  always @(posedge clk) begin
    rv_r <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        rv_r <= 1'b1;
        rd_r <= memf(paddr);
        pend <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (bus.mem_req && bus.mem_gnt) begin
      grants_done <= grants_done + 1;
      if (rsp_lat <= 1) begin
        rv_r <= 1'b1;
        rd_r <= memf(bus.mem_addr);
      end else begin
        pend  <= 1'b1;
        paddr <= bus.mem_addr;
        cnt   <= rsp_lat - 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && bus.enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got pc %h instr %h, required no delivery",
                 bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        check("instr_pc", bus.instr_pc, e.pc);
        check("instr", bus.instr, e.ins);
      end
    end
  end

  task automatic release_rst();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check({name, "_undelivered"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // kind 0: grant at addr; kind 1: any grant; kind 2: read response.
  task automatic wait_ev(input string name, input int kind, input logic [31:0] addr);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       hit = bus.mem_req && bus.mem_gnt && (bus.mem_addr == addr);
        1:       hit = bus.mem_req && bus.mem_gnt;
        2:       hit = bus.mem_rvalid;
        default: hit = 1'b0;
      endcase
    end
    check({name, "_seen"}, {31'b0, hit}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_mem_req"}, {31'b0, bus.mem_req}, 32'h0);
    check({name, "_mem_addr"}, bus.mem_addr, 32'h0);
    check({name, "_enable"}, {31'b0, bus.enable}, 32'h0);
    check({name, "_instr"}, bus.instr, NoOp);
    check({name, "_instr_pc"}, bus.instr_pc, 32'h0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int unsigned base;
    bus.dec_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset values, then streaming from RESET_PC.
    #1 check_reset_outputs("rst");
    grant_limit = grants_done + 6;
    expect_run(32'h0, 6);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("first_mem_req", {31'b0, bus.mem_req}, 32'h1);
    check("first_mem_addr", bus.mem_addr, 32'h0);
    drain("stream");

    // Decoder stall fills the buffer and parks the FSM in hold.
    rst = 1'b0;
    bus.dec_ready = 1'b0;
    base = grants_done;
    grant_limit = base + 10;
    release_rst();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("hold_mem_req", {31'b0, bus.mem_req}, 32'h0);
    check("hold_grants", grants_done - base, 32'd2);
    expect_run(32'h0, 10);
    @(posedge clk);
    #1 bus.dec_ready = 1'b1;
    drain("hold");

    // Redirect while the grant for 0x10 is outstanding.
    rst = 1'b0;
    rsp_lat = 3;
    base = grants_done;
    grant_limit = base + 9;
    expect_run(32'h0, 4);
    expect_run(32'h100, 4);
    release_rst();
    wait_ev("gnt10", 0, 32'h10);
    @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0100;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    @(negedge clk);
    check("drop_pending_mem_req", {31'b0, bus.mem_req}, 32'h0);
    drain("redir_wait");

    // Redirect in the same cycle as the grant.
    rst = 1'b0;
    rsp_lat = 1;
    base = grants_done;
    grant_limit = base + 4;
    expect_run(32'h200, 3);
    release_rst();
    wait_ev("gnt0", 1, 32'h0);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    drain("redir_gnt");

    // Redirect in the same cycle as the response.
    rst = 1'b0;
    base = grants_done;
    grant_limit = base + 3;
    expect_run(32'h300, 2);
    release_rst();
    wait_ev("rvalid0", 2, 32'h0);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    drain("redir_rvalid");

    // Redirect in S_REQ to a misaligned address near the top; PC wraps.
    rst = 1'b0;
    base = grants_done;
    grant_limit = base;
    release_rst();
    @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF9;
    @(posedge clk);
    #1 bus.redirect = 1'b0;
    @(negedge clk);
    check("redir_req_mem_req", {31'b0, bus.mem_req}, 32'h1);
    check("redir_req_mem_addr", bus.mem_addr, 32'hFFFF_FFF8);
    expect_run(32'hFFFF_FFF8, 3);
    grant_limit = base + 3;
    drain("wrap");

    // Reset in S_WAIT: outputs drop at once, stale response is ignored.
    rst = 1'b0;
    rsp_lat = 3;
    base = grants_done;
    grant_limit = base + 5;
    expect_run(32'h0, 1);
    release_rst();
    wait_ev("gnt4", 0, 32'h4);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("midwait");
    base = grants_done;
    grant_limit = base + 2;
    expect_run(32'h0, 2);
    release_rst();
    @(negedge clk);
    check("postrst_mem_req", {31'b0, bus.mem_req}, 32'h1);
    check("postrst_mem_addr", bus.mem_addr, 32'h0);
    drain("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal range 2..8.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mem_req  out  1  fetch request valid.
REQ-006 mem_addr  out  32  word-aligned fetch address; valid while mem_req=1.
REQ-007 mem_gnt  in  1  request accepted this cycle when mem_req=1.
REQ-008 mem_rvalid  in  1  read data valid; one response per grant, in order, earliest one cycle after the grant.
REQ-009 mem_rdata  in  32  instruction word, valid with mem_rvalid.
REQ-010 dec_ready  in  1  decoder can accept an instruction this cycle.
REQ-011 instr  out  instruction_t  head-of-buffer instruction; NO_OP when the buffer is empty.
REQ-012 instr_pc  out  32  address of instr; 0 when the buffer is empty.
REQ-013 enable  out  1  one-cycle pulse per instruction handed to the decoder.
REQ-014 redirect  in  1  flush and restart fetch, from branch/jump resolution.
REQ-015 redirect_pc  in  32  new fetch address; bits [1:0] ignored and treated as 0.

Function
REQ-016 FSM states: S_REQ (mem_req=1), S_WAIT (one grant outstanding, mem_req=0), S_HOLD (no buffer room, mem_req=0).
REQ-017 At most one outstanding request at any time.
REQ-018 Issue condition: buffer count + outstanding < BUF_DEPTH, using registered count.
REQ-019 Transitions:
- S_REQ -> S_WAIT on mem_gnt.
- S_WAIT -> S_REQ on mem_rvalid when the issue condition holds after the write.
- S_WAIT -> S_HOLD on mem_rvalid otherwise.
- S_HOLD -> S_REQ when an enable pop frees an entry.
REQ-020 mem_addr and mem_req SHALL stay stable in S_REQ until mem_gnt, except on redirect.
REQ-021 On grant, fetch PC increments by 4 modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 On mem_rvalid (not dropped), {mem_rdata, granted address} is written to the buffer tail the same edge.
REQ-023 enable = buffer non-empty & dec_ready & !redirect; the head pops on the same edge.
REQ-024 A push and a pop in the same cycle leave the count unchanged and preserve order.
REQ-025 Buffer pointers wrap modulo BUF_DEPTH.
REQ-026 Overflow is impossible by REQ-018; a push to a full buffer is a design error, flagged by an assertion.
REQ-027 Redirect, effective on the same edge:
- Buffer flushed and count set to 0.
- Fetch PC set to redirect_pc.
- If a grant is outstanding, a drop flag is set, and the next mem_rvalid is discarded and clears the flag.
REQ-028 With redirect=1 in S_REQ, mem_req stays asserted and mem_addr shows the redirected address from the next cycle.
REQ-029 No new request issues while the drop flag is set and the response is still pending.
REQ-030 Redirect in the same cycle as mem_gnt: the granted response is dropped and the fetch PC becomes redirect_pc, not the increment.
REQ-031 Redirect in the same cycle as mem_rvalid: the response is discarded.
REQ-032 enable is never asserted in a cycle with redirect=1.
REQ-033 Steady-state latency:
- Grant to enable: 2 cycles minimum (response, then buffer head).
- Throughput: one instruction per 2 cycles with single-cycle grant and response.

Reset
REQ-034 On rst=0, immediately and asynchronously:
- State S_REQ; fetch PC = RESET_PC; buffer empty; drop flag cleared.
- mem_req=0, mem_addr=RESET_PC, enable=0, instr=NO_OP, instr_pc=0.
REQ-035 First cycle after rst deasserts: mem_req=1, mem_addr=RESET_PC.
REQ-036 Reset during an outstanding request discards that response; no response before the first post-reset grant is accepted.

Verification
REQ-037 Reset release, memory with 1-cycle grant and response, dec_ready=1 -> enable pulses with instr_pc 0,4,8,...; instr matches memory contents.
REQ-038 dec_ready=0 for 10 cycles -> exactly BUF_DEPTH entries buffered and mem_req=0 (S_HOLD); dec_ready=1 -> those entries delivered in order, then fetch resumes at the next address.
REQ-039 Redirect to 32'h0000_0100 while a grant for 0x10 is outstanding -> 0x10 data never delivered; next enable has instr_pc=0x100.
REQ-040 Redirect asserted in the same cycle as mem_gnt and as mem_rvalid (separate runs) -> no stale instruction delivered; fetch restarts at redirect_pc.
REQ-041 Redirect to 32'hFFFF_FFF8 -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-042 rst asserted mid-S_WAIT -> all outputs take their reset values immediately; after release, the first mem_addr is RESET_PC.
